// File: rtl/spi_display_receiver.sv
// SPI responder modelling a MAX7219-style display register file.
// The SPI pins are oversampled in the clk domain and each 16-bit MSB-first
// frame is decoded as {ignored[3:0], addr[3:0], data[7:0]}.
module spi_display_receiver #(
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       spi_cs,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       frame_valid,
  output logic       frame_error,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       shutdown_n,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       display_test,
  input  logic [2:0] rd_sel,
  output logic [7:0] rd_raw,
  output logic [3:0] rd_char,
  output logic       rd_dp
);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_COMMIT} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] cs_sync_reg, sck_sync_reg, mosi_sync_reg;
  logic [SYNC_STAGES:0]   cs_sync_next, sck_sync_next, mosi_sync_next;
  logic                   cs_d_reg, sck_d_reg;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_rise, cs_fall, sck_rise;

  logic [WORD_BITS-1:0] shift_reg;
  logic [4:0]           bit_cnt_reg;
  logic                 count_ok;

  logic clear_en, shift_en, commit_en, error_en;
  logic frame_valid_reg, frame_error_reg;
  logic [3:0] frame_addr_reg, intensity_reg;
  logic [7:0] frame_data_reg, decode_mode_reg;
  logic [2:0] scan_limit_reg;
  logic       shutdown_n_reg, display_test_reg;
  logic [3:0] commit_addr;
  logic [7:0] commit_data;
  logic [63:0] digit_flat;

  // Each chain shifts the raw pin in at bit 0; the top bit is the synchronised value.
  assign cs_sync_next   = {cs_sync_reg, spi_cs};
  assign sck_sync_next  = {sck_sync_reg, spi_sck};
  assign mosi_sync_next = {mosi_sync_reg, spi_mosi};

  // Synchroniser chains plus one delay stage for edge detection; CS idles high out of reset.
  always_ff @(posedge clk) begin
    if (res) begin
      cs_sync_reg   <= '1;
      sck_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      cs_d_reg      <= 1'b1;
      sck_d_reg     <= 1'b0;
    end else begin
      cs_sync_reg   <= cs_sync_next[SYNC_STAGES-1:0];
      sck_sync_reg  <= sck_sync_next[SYNC_STAGES-1:0];
      mosi_sync_reg <= mosi_sync_next[SYNC_STAGES-1:0];
      cs_d_reg      <= cs_s;
      sck_d_reg     <= sck_s;
    end
  end

  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_d_reg;
  assign cs_fall  = ~cs_s & cs_d_reg;
  assign sck_rise = sck_s & ~sck_d_reg;
  assign count_ok = (bit_cnt_reg == 5'(WORD_BITS));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (res) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic; a CS fall inside RECV simply restarts the frame.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (cs_fall) state_next = ST_RECV;
      ST_RECV: begin
        if (cs_fall)      state_next = ST_RECV;
        else if (cs_rise) state_next = count_ok ? ST_COMMIT : ST_IDLE;
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; CS rise takes priority so an SCK rise in the same cycle is dropped.
  always_comb begin
    clear_en  = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    error_en  = 1'b0;
    case (state_reg)
      ST_IDLE: clear_en = cs_fall;
      ST_RECV: begin
        if (cs_fall)                 clear_en = 1'b1;
        else if (cs_rise)            error_en = ~count_ok;
        else if (sck_rise && !cs_s)  shift_en = 1'b1;
      end
      ST_COMMIT: commit_en = 1'b1;
      default: ;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk) begin
    if (res || clear_en) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (shift_en) begin
      shift_reg   <= {shift_reg[WORD_BITS-2:0], mosi_s};
      if (bit_cnt_reg != 5'd31) bit_cnt_reg <= bit_cnt_reg + 5'd1;
    end
  end

  assign commit_addr = shift_reg[11:8];
  assign commit_data = shift_reg[7:0];

  // Status pulses, last-frame fields and control registers, updated on commit.
  always_ff @(posedge clk) begin
    if (res) begin
      frame_valid_reg  <= 1'b0;
      frame_error_reg  <= 1'b0;
      frame_addr_reg   <= '0;
      frame_data_reg   <= '0;
      decode_mode_reg  <= '0;
      intensity_reg    <= '0;
      scan_limit_reg   <= '0;
      shutdown_n_reg   <= 1'b0;
      display_test_reg <= 1'b0;
    end else begin
      frame_valid_reg <= commit_en;
      frame_error_reg <= error_en;
      if (commit_en) begin
        frame_addr_reg <= commit_addr;
        frame_data_reg <= commit_data;
        case (commit_addr)
          4'h9: decode_mode_reg  <= commit_data;
          4'hA: intensity_reg    <= commit_data[3:0];
          4'hB: scan_limit_reg   <= commit_data[2:0];
          4'hC: shutdown_n_reg   <= commit_data[0];
          4'hF: display_test_reg <= commit_data[0];
          default: ;
        endcase
      end
    end
  end

  // Digit registers 0x01..0x08, one per generate instance.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [7:0] digit_reg;
      // Capture the frame data when the committed address selects this digit.
      always_ff @(posedge clk) begin
        if (res)                                          digit_reg <= '0;
        else if (commit_en && commit_addr == 4'(gi + 1))  digit_reg <= commit_data;
      end
      assign digit_flat[gi*8 +: 8] = digit_reg;
    end
  endgenerate

  assign frame_valid  = frame_valid_reg;
  assign frame_error  = frame_error_reg;
  assign frame_addr   = frame_addr_reg;
  assign frame_data   = frame_data_reg;
  assign decode_mode  = decode_mode_reg;
  assign intensity    = intensity_reg;
  assign scan_limit   = scan_limit_reg;
  assign shutdown_n   = shutdown_n_reg;
  assign display_test = display_test_reg;

  assign rd_raw  = digit_flat[{rd_sel, 3'b000} +: 8];
  assign rd_char = decode_mode_reg[rd_sel] ? rd_raw[3:0] : 4'hF;
  assign rd_dp   = rd_raw[7];

endmodule

// File: tb/tb_spi_display_receiver.sv
// Bench for spi_display_receiver: bit-banged SPI master, register-file model, pulse monitor.
`timescale 1ns/1ps
module tb_spi_display_receiver;

  logic       clk = 1'b0;
  logic       res, spi_cs, spi_sck, spi_mosi;
  logic       frame_valid, frame_error, shutdown_n, display_test, rd_dp;
  logic [3:0] frame_addr, intensity, rd_char;
  logic [7:0] frame_data, decode_mode, rd_raw;
  logic [2:0] scan_limit, rd_sel;

  spi_display_receiver #(.WORD_BITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .res(res), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .frame_addr(frame_addr), .frame_data(frame_data),
    .shutdown_n(shutdown_n), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .display_test(display_test),
    .rd_sel(rd_sel), .rd_raw(rd_raw), .rd_char(rd_char), .rd_dp(rd_dp)
  );

  always #500 clk = ~clk;

  int pass_cnt = 0;
  int check_cnt = 0;
  int valid_seen = 0;
  int error_seen = 0;
  int both_seen = 0;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_valid) valid_seen++;
    if (frame_error) error_seen++;
    if (frame_valid && frame_error) both_seen++;
  end

  // Reference model of the display register file.
  logic [7:0] m_digit [8];
  logic [7:0] m_decode, m_data;
  logic [3:0] m_int, m_addr;
  logic [2:0] m_scan;
  logic       m_shut, m_test;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
    m_decode = 0; m_int = 0; m_scan = 0; m_shut = 0; m_test = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_frame(input logic [15:0] w);
    int a;
    a = int'(w[11:8]);
    m_addr = w[11:8];
    m_data = w[7:0];
    if (a >= 1 && a <= 8) m_digit[a-1] = w[7:0];
    else if (a == 9)  m_decode = w[7:0];
    else if (a == 10) m_int = w[3:0];
    else if (a == 11) m_scan = w[2:0];
    else if (a == 12) m_shut = w[0];
    else if (a == 15) m_test = w[0];
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the low nbits of value MSB first, SCK = clk/4.
  task automatic shift_bits(input logic [31:0] value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = value[i];
      wait_clk(2);
      spi_sck = 1'b1;
      wait_clk(2);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] value, input int nbits, input int gap);
    spi_cs = 1'b0;
    wait_clk(2);
    shift_bits(value, nbits);
    wait_clk(2);
    spi_cs = 1'b1;
    wait_clk(gap);
  endtask

  task automatic test_reset();
    res = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; rd_sel = 3'd0;
    wait_clk(4);
    res = 1'b0;
    wait_clk(2);
    model_reset();
    check_cnt++; if (frame_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", frame_valid); else pass_cnt++;
    check_cnt++; if (frame_error !== 1'b0) $display("FAIL reset_error got %b want 0", frame_error); else pass_cnt++;
    check_cnt++; if (shutdown_n !== 1'b0) $display("FAIL reset_shutdown got %b want 0", shutdown_n); else pass_cnt++;
    check_cnt++; if ({decode_mode, intensity, scan_limit, display_test} !== 16'h0)
      $display("FAIL reset_ctrl got %h %h %h %b want all 0", decode_mode, intensity, scan_limit, display_test); else pass_cnt++;
    check_cnt++; if ({frame_addr, frame_data} !== 12'h0)
      $display("FAIL reset_frame got %h %h want 0 0", frame_addr, frame_data); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      check_cnt++; if (rd_raw !== 8'h00 || rd_char !== 4'hF)
        $display("FAIL reset_digit%0d got raw %h char %h want 00 f", i, rd_raw, rd_char); else pass_cnt++;
    end
  endtask

  task automatic test_shutdown();
    int v0, e0, lat;
    bit found;
    spi_cs = 1'b0;
    wait_clk(2);
    shift_bits(32'h0C01, 16);
    wait_clk(2);
    v0 = valid_seen; e0 = error_seen; lat = 0; found = 0;
    spi_cs = 1'b1;
    for (int n = 1; n <= 20 && !found; n++) begin
      @(negedge clk);
      if (frame_valid) begin lat = n; found = 1; end
    end
    wait_clk(6);
    model_frame(16'h0C01);
    check_cnt++; if (lat !== 4) $display("FAIL shutdown_latency got %0d want 4 cycles", lat); else pass_cnt++;
    check_cnt++; if (valid_seen - v0 !== 1) $display("FAIL shutdown_valid_count got %0d want 1", valid_seen - v0); else pass_cnt++;
    check_cnt++; if (error_seen - e0 !== 0) $display("FAIL shutdown_error_count got %0d want 0", error_seen - e0); else pass_cnt++;
    check_cnt++; if (frame_addr !== 4'hC || frame_data !== 8'h01)
      $display("FAIL shutdown_frame got %h %h want c 01", frame_addr, frame_data); else pass_cnt++;
    check_cnt++; if (shutdown_n !== 1'b1) $display("FAIL shutdown_n got %b want 1", shutdown_n); else pass_cnt++;
  endtask

  task automatic test_decode(input logic [7:0] mode, input logic [3:0] want_char);
    send_frame({24'h0, 8'h09, mode}, 16, 8); model_frame({8'h09, mode});
    send_frame(32'h0385, 16, 8);             model_frame(16'h0385);
    rd_sel = 3'd2;
    #1;
    check_cnt++; if (decode_mode !== mode) $display("FAIL decode_mode got %h want %h", decode_mode, mode); else pass_cnt++;
    check_cnt++; if (rd_raw !== 8'h85) $display("FAIL decode_raw got %h want 85", rd_raw); else pass_cnt++;
    check_cnt++; if (rd_char !== want_char) $display("FAIL decode_char got %h want %h", rd_char, want_char); else pass_cnt++;
    check_cnt++; if (rd_dp !== 1'b1) $display("FAIL decode_dp got %b want 1", rd_dp); else pass_cnt++;
  endtask

  task automatic test_bad_length();
    int v0, e0;
    int lens [2] = '{8, 17};
    foreach (lens[k]) begin
      v0 = valid_seen; e0 = error_seen;
      send_frame($urandom, lens[k], 8);
      check_cnt++; if (error_seen - e0 !== 1)
        $display("FAIL badlen%0d_error_count got %0d want 1", lens[k], error_seen - e0); else pass_cnt++;
      check_cnt++; if (valid_seen - v0 !== 0)
        $display("FAIL badlen%0d_valid_count got %0d want 0", lens[k], valid_seen - v0); else pass_cnt++;
    end
    check_cnt++; if ({decode_mode, intensity, scan_limit, shutdown_n, display_test} !== {m_decode, m_int, m_scan, m_shut, m_test})
      $display("FAIL badlen_ctrl got %h %h %h %b %b want %h %h %h %b %b", decode_mode, intensity, scan_limit,
               shutdown_n, display_test, m_decode, m_int, m_scan, m_shut, m_test); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      check_cnt++; if (rd_raw !== m_digit[i]) $display("FAIL badlen_digit%0d got %h want %h", i, rd_raw, m_digit[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    spi_cs = 1'b0;
    wait_clk(2);
    shift_bits(32'h0A07 >> 7, 9);
    v0 = valid_seen; e0 = error_seen;
    res = 1'b1;
    wait_clk(1);
    spi_cs = 1'b1; spi_sck = 1'b0;
    wait_clk(4);
    res = 1'b0;
    model_reset();
    wait_clk(6);
    check_cnt++; if (intensity !== 4'h0) $display("FAIL midreset_intensity got %h want 0", intensity); else pass_cnt++;
    check_cnt++; if (shutdown_n !== m_shut) $display("FAIL midreset_shutdown got %b want %b", shutdown_n, m_shut); else pass_cnt++;
    check_cnt++; if (valid_seen - v0 !== 0 || error_seen - e0 !== 0)
      $display("FAIL midreset_pulses got valid %0d error %0d want 0 0", valid_seen - v0, error_seen - e0); else pass_cnt++;
    send_frame(32'h0A07, 16, 8);
    model_frame(16'h0A07);
    check_cnt++; if (intensity !== 4'h7) $display("FAIL midreset_intensity2 got %h want 7", intensity); else pass_cnt++;
    check_cnt++; if (valid_seen - v0 !== 1 || error_seen - e0 !== 0)
      $display("FAIL midreset_pulses2 got valid %0d error %0d want 1 0", valid_seen - v0, error_seen - e0); else pass_cnt++;
  endtask

  task automatic test_random_frames();
    int v0, e0;
    logic [15:0] w;
    v0 = valid_seen; e0 = error_seen;
    for (int n = 0; n < 30; n++) begin
      w = 16'($urandom);
      send_frame({16'h0, w}, 16, 8);
      model_frame(w);
      check_cnt++; if (frame_addr !== m_addr || frame_data !== m_data)
        $display("FAIL random%0d_frame word %h got %h %h want %h %h", n, w, frame_addr, frame_data, m_addr, m_data); else pass_cnt++;
    end
    check_cnt++; if (valid_seen - v0 !== 30 || error_seen - e0 !== 0)
      $display("FAIL random_pulses got valid %0d error %0d want 30 0", valid_seen - v0, error_seen - e0); else pass_cnt++;
    check_cnt++; if ({decode_mode, intensity, scan_limit, shutdown_n, display_test} !== {m_decode, m_int, m_scan, m_shut, m_test})
      $display("FAIL random_ctrl got %h %h %h %b %b want %h %h %h %b %b", decode_mode, intensity, scan_limit,
               shutdown_n, display_test, m_decode, m_int, m_scan, m_shut, m_test); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      check_cnt++; if (rd_raw !== m_digit[i] || rd_char !== (m_decode[i] ? m_digit[i][3:0] : 4'hF) || rd_dp !== m_digit[i][7])
        $display("FAIL random_digit%0d got %h %h %b want raw %h", i, rd_raw, rd_char, rd_dp, m_digit[i]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    logic [7:0] sent [6];
    logic [15:0] w;
    v0 = valid_seen; e0 = error_seen;
    for (int k = 0; k < 6; k++) begin
      sent[k] = 8'($urandom);
      w = {4'($urandom), 4'(k + 1), sent[k]};
      send_frame({16'h0, w}, 16, 2);
    end
    wait_clk(8);
    check_cnt++; if (valid_seen - v0 !== 6 || error_seen - e0 !== 0)
      $display("FAIL b2b_pulses got valid %0d error %0d want 6 0", valid_seen - v0, error_seen - e0); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      rd_sel = 3'(k);
      #1;
      check_cnt++; if (rd_raw !== sent[k]) $display("FAIL b2b_digit%0d got %h want %h", k + 1, rd_raw, sent[k]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_shutdown();
    test_decode(8'hFF, 4'h5);
    test_decode(8'h00, 4'hF);
    test_bad_length();
    test_reset_mid_frame();
    test_random_frames();
    test_back_to_back();
    check_cnt++; if (both_seen !== 0) $display("FAIL pulse_overlap got %0d cycles want 0", both_seen); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
